// File: rtl/uart_axi_arb_pkg.sv
// Shared types for the two-requester AXI4-Lite arbiter in front of the UART slave.
// Holds the FSM state encodings and the AXI response codes.
package uart_axi_arb_pkg;

    typedef enum logic [1:0] {WIdle, WAddr, WResp} wr_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/uart_axi_rr_arb2.sv
// Two-way round-robin picker: the requester named by i_prio wins a tie.
module uart_axi_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req[i_prio]) begin
            o_grant[i_prio] = 1'b1;
        end else if (i_req[~i_prio]) begin
            o_grant[~i_prio] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_axi_arbiter.sv
// Shares the UART AXI4-Lite slave between two masters; write and read paths are
// arbitrated independently, one outstanding transaction each.
module uart_axi_arbiter
    import uart_axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [ADDR_W-1:0]     s0_axi_awaddr,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_W-1:0]     s0_axi_wdata,
    input  logic [DATA_W/8-1:0]   s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_W-1:0]     s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_W-1:0]     s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_W-1:0]     s1_axi_awaddr,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [DATA_W-1:0]     s1_axi_wdata,
    input  logic [DATA_W/8-1:0]   s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_W-1:0]     s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_W-1:0]     s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [1:0]            wr_grant,
    output logic [1:0]            rd_grant
);

    wr_state_e  r_wr_state;
    rd_state_e  r_rd_state;
    logic [1:0] r_wr_grant, r_rd_grant;
    logic       r_wr_prio, r_rd_prio;
    logic       r_aw_done, r_w_done, r_ar_done;

    logic [1:0] w_wr_pick, w_rd_pick;
    logic       w_run, w_wsel, w_rsel;
    logic       w_in_waddr, w_in_wresp, w_in_raddr, w_in_rdata;
    logic       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    uart_axi_rr_arb2 u_wr_arb (
        .i_req   ({s1_axi_awvalid, s0_axi_awvalid}),
        .i_prio  (r_wr_prio),
        .o_grant (w_wr_pick)
    );

    uart_axi_rr_arb2 u_rd_arb (
        .i_req   ({s1_axi_arvalid, s0_axi_arvalid}),
        .i_prio  (r_rd_prio),
        .o_grant (w_rd_pick)
    );

    // Handshake outputs are gated by reset so they read 0 in every reset cycle.
    assign w_run      = ~s_axi_areset;
    assign w_wsel     = r_wr_grant[1];
    assign w_rsel     = r_rd_grant[1];
    assign w_in_waddr = w_run && (r_wr_state == WAddr);
    assign w_in_wresp = w_run && (r_wr_state == WResp);
    assign w_in_raddr = w_run && (r_rd_state == RAddr);
    assign w_in_rdata = w_run && (r_rd_state == RData);

    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;
    assign w_b_hs  = m_axi_bvalid & m_axi_bready;
    assign w_ar_hs = m_axi_arvalid & m_axi_arready;
    assign w_r_hs  = m_axi_rvalid & m_axi_rready;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wr_state <= WIdle;
            r_wr_grant <= 2'b00;
            r_wr_prio  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            unique case (r_wr_state)
                WIdle: if (|w_wr_pick) begin
                    r_wr_grant <= w_wr_pick;
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                    r_wr_state <= WAddr;
                end
                WAddr: begin
                    r_aw_done <= r_aw_done | w_aw_hs;
                    r_w_done  <= r_w_done | w_w_hs;
                    if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_wr_state <= WResp;
                end
                WResp: if (w_b_hs) begin
                    r_wr_prio  <= r_wr_grant[0];
                    r_wr_grant <= 2'b00;
                    r_wr_state <= WIdle;
                end
                default: r_wr_state <= WIdle;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rd_state <= RIdle;
            r_rd_grant <= 2'b00;
            r_rd_prio  <= 1'b0;
            r_ar_done  <= 1'b0;
        end else begin
            unique case (r_rd_state)
                RIdle: if (|w_rd_pick) begin
                    r_rd_grant <= w_rd_pick;
                    r_ar_done  <= 1'b0;
                    r_rd_state <= RAddr;
                end
                RAddr: if (w_ar_hs) begin
                    r_ar_done  <= 1'b1;
                    r_rd_state <= RData;
                end
                RData: if (w_r_hs) begin
                    r_rd_prio  <= r_rd_grant[0];
                    r_rd_grant <= 2'b00;
                    r_rd_state <= RIdle;
                end
                default: r_rd_state <= RIdle;
            endcase
        end
    end

    assign wr_grant = w_run ? r_wr_grant : 2'b00;
    assign rd_grant = w_run ? r_rd_grant : 2'b00;

    assign m_axi_awaddr  = w_wsel ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awvalid = w_in_waddr & ~r_aw_done & (w_wsel ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_wdata   = w_wsel ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb   = w_wsel ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wvalid  = w_in_waddr & ~r_w_done & (w_wsel ? s1_axi_wvalid : s0_axi_wvalid);
    assign m_axi_bready  = w_in_wresp & (w_wsel ? s1_axi_bready : s0_axi_bready);

    assign s0_axi_awready = w_in_waddr & r_wr_grant[0] & ~r_aw_done & m_axi_awready;
    assign s1_axi_awready = w_in_waddr & r_wr_grant[1] & ~r_aw_done & m_axi_awready;
    assign s0_axi_wready  = w_in_waddr & r_wr_grant[0] & ~r_w_done & m_axi_wready;
    assign s1_axi_wready  = w_in_waddr & r_wr_grant[1] & ~r_w_done & m_axi_wready;
    assign s0_axi_bvalid  = w_in_wresp & r_wr_grant[0] & m_axi_bvalid;
    assign s1_axi_bvalid  = w_in_wresp & r_wr_grant[1] & m_axi_bvalid;
    assign s0_axi_bresp   = m_axi_bresp;
    assign s1_axi_bresp   = m_axi_bresp;

    assign m_axi_araddr  = w_rsel ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arvalid = w_in_raddr & ~r_ar_done & (w_rsel ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_rready  = w_in_rdata & (w_rsel ? s1_axi_rready : s0_axi_rready);

    assign s0_axi_arready = w_in_raddr & r_rd_grant[0] & ~r_ar_done & m_axi_arready;
    assign s1_axi_arready = w_in_raddr & r_rd_grant[1] & ~r_ar_done & m_axi_arready;
    assign s0_axi_rvalid  = w_in_rdata & r_rd_grant[0] & m_axi_rvalid;
    assign s1_axi_rvalid  = w_in_rdata & r_rd_grant[1] & m_axi_rvalid;
    assign s0_axi_rdata   = m_axi_rdata;
    assign s1_axi_rdata   = m_axi_rdata;
    assign s0_axi_rresp   = m_axi_rresp;
    assign s1_axi_rresp   = m_axi_rresp;

endmodule

// File: doc/uart_axi_arbiter.md
# uart_axi_arbiter

Two-requester AXI4-Lite arbiter that shares the UART register slave between two masters (host CPU and DMA/debug agent). Write and read paths are arbitrated independently with round-robin priority, one outstanding transaction per path. It sits directly in front of the UART AXI4-Lite slave and keeps every downstream channel AXI4-Lite compliant: VALID held until READY, payload stable while stalled.

## Interface

- ADDR_W, 32, address width, all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  synchronous, active-high reset
- s{0,1}_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  requester write address
- s{0,1}_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  requester write data
- s{0,1}_axi_bresp/bvalid/bready  out/out/in  2/1/1  requester write response
- s{0,1}_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  requester read address
- s{0,1}_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  requester read data
- m_axi_* (aw, w, b, ar, r sets as above, directions mirrored)  to UART slave
- wr_grant  out  2  one-hot current write owner, 0 when idle (debug)
- rd_grant  out  2  one-hot current read owner, 0 when idle (debug)

## Operation

- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_IDLE.
  - W_IDLE: a requester is eligible when its awvalid is high.
  - Pick by round-robin pointer wr_prio: the requester equal to wr_prio wins ties.
  - Latch the one-hot grant, go to W_ADDR.
- W_ADDR: mux the granted requester's aw and w channels to m_axi.
  - Track aw_done and w_done independently; each sets on its m-side handshake.
  - When both are done (same cycle allowed), go to W_RESP.
  - Once a channel is done, forward its VALID as 0.
- W_RESP: route m_axi_bvalid/bresp to the granted requester only and route its bready back.
  - On the b handshake, set wr_prio to the non-granted requester and go to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. Same rules, using arvalid, the ar handshake, the r handshake and rd_prio.
- Non-granted requesters see all READY and response VALID outputs at 0.
- A pending requester is therefore served within one foreign transaction (no starvation).
- Response payload (bresp, rdata, rresp) goes to every requester; only the grantee's VALID is asserted.
- A requester asserting wvalid without awvalid is not eligible; its W channel waits.

## Timing

- Reset, and for every cycle s_axi_areset is high:
  - FSM state: both FSMs IDLE.
  - Priority: wr_prio = rd_prio = 0.
  - Grants: wr_grant = rd_grant = 0.
  - Handshake outputs: all m_axi_*valid, m_axi_bready, m_axi_rready, s*_awready/wready/arready/bvalid/rvalid = 0.
  - Done flags: aw_done and w_done cleared.
- Reset mid-transaction abandons the transaction with no completion to any requester. The downstream slave is reset by the same signal.
- Grant latency: the grant is registered. Request at cycle T puts m_axi_awvalid (or m_axi_arvalid) high at T+1.
- Forwarding in ADDR, RESP and DATA states is combinational through the registered grant mux. There is no added latency per beat.
- Earliest write:
  - T: awvalid and wvalid.
  - T+1: m_axi aw and w handshake.
  - T+2: W_RESP.
  - bvalid/bready at T+2 returns to W_IDLE at T+3.
  - Next grant no earlier than T+3.
- Read and write FSMs are fully independent. A simultaneous read by one requester and write by the other proceeds concurrently.
- Payload stability: the mux select is frozen while granted. Stability then follows from requester compliance.

## Structure

- Package uart_axi_arb_pkg: the wr_state_e and rd_state_e enums, and the AXI resp localparams (OKAY=2'b00, SLVERR=2'b10).
- One sub-module, uart_axi_rr_arb2: 2-way round-robin picker with req[1:0] and prio in, one-hot grant out. It is instantiated twice (write, read).
- Top module holds the two FSMs and the channel muxes.
- The AXI channel property checker binds to the m_axi side and to each s side.

## Test plan

- Single write: s0 awaddr=0x04, wdata=0x55, wstrb=0xF at T -> m_axi_awvalid and wvalid at T+1 carrying 0x04/0x55; bresp=OKAY returned on s0 only; s1_axi_bvalid stays 0.
- Simultaneous writes after reset: s0 and s1 both request at T -> s0 served first; s1 granted only after s0's b handshake; wr_prio=1 afterwards. A repeat contention serves s1 first.
- Split AW/W: s1 wvalid at T+3 after awvalid at T -> W_ADDR holds; m_axi_awvalid deasserts after its handshake; W_RESP entered only after the w handshake.
- Concurrent paths: s0 read of 0x08 and s1 write of 0x0C at the same cycle -> both proceed in parallel; rdata=0x0000_00A5 delivered to s0 only.
- Backpressure: m_axi_awready=0 for 5 cycles -> m_axi_awvalid and awaddr stay stable; s1_axi_awready stays 0 throughout.
- Reset mid-read: assert reset in R_DATA -> all VALIDs 0 next cycle; rd_grant=0; no rvalid delivered; a fresh read after release completes normally.
